// File: rtl/riscv_pkg.sv
// Shared core definitions used by the fetch, hazard and PC redirect logic.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    // RUN: normal sequencing. PEND: a taken target waits for a fetch handshake.
    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_redirect_unit_flush_timer.sv
// Down-counter that keeps the pipeline flush asserted for a fixed number of
// cycles after each accepted taken branch.
module flush_timer #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    output logic busy_o
);

    localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

    logic [CW-1:0] count_q;

    // Load on an accepted branch, otherwise count down to zero and stop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= CW'(FLUSH_CYCLES);
        end else if (count_q != '0) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign busy_o = (count_q != '0);

endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter owner: sequential fetch, branch redirects (immediate or
// deferred until the fetch handshake), and IF/ID + ID/EX flush generation.
//
// Handshake: a fetch request is transferred on a rising edge where
// fetch_valid_o && fetch_ready_i. While valid is high and ready is low the
// request (pc_o) is held stable; valid never drops once raised until reset.
module pc_redirect_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC     = riscv_pkg::RESET_PC,
    parameter int unsigned     FLUSH_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            stall_i,
    input  logic            fetch_ready_i,
    output logic            fetch_valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            flush_o,
    output logic            redirect_pending_o,
    output logic            misalign_o,
    output logic            state_o
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            fetch_valid_q;
    logic            misalign_q, misalign_d;
    logic            fire;
    logic            branch_accept;
    logic [XLEN-1:0] target_aligned;

    assign fire           = fetch_valid_q & fetch_ready_i;
    // While flushing or pending, EX holds a bubble, so its branch decision is stale.
    assign branch_accept  = branch_taken_i & ~flush_o & (state_q == RUN);
    assign target_aligned = {branch_target_i[XLEN-1:2], 2'b00};

    // Next-state, next-PC and pending-target selection: redirect > stall > increment.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        misalign_d = branch_accept & (branch_target_i[1:0] != 2'b00);
        case (state_q)
            RUN: begin
                if (branch_accept) begin
                    if (fire || !fetch_valid_q) begin
                        pc_d = target_aligned;
                    end else begin
                        target_d = target_aligned;
                        state_d  = PEND;
                    end
                end else if (fire && !stall_i) begin
                    pc_d = pc_q + XLEN'(4);
                end
            end
            PEND: begin
                if (fire) begin
                    pc_d    = target_q;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // PC, pending target, FSM state and one-shot misalign flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            target_q      <= '0;
            fetch_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            target_q      <= target_d;
            fetch_valid_q <= 1'b1;
            misalign_q    <= misalign_d;
        end
    end

    flush_timer #(
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) u_flush_timer (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .load_i(branch_accept),
        .busy_o(flush_o)
    );

    assign fetch_valid_o      = fetch_valid_q;
    assign pc_o               = pc_q;
    assign pc_plus4_o         = pc_q + XLEN'(4);
    assign redirect_pending_o = (state_q == PEND);
    assign misalign_o         = misalign_q;
    assign state_o            = state_q;

endmodule
